// File: rtl/pa_risc_trace_buffer_pkg.sv
// Shared definitions for the PA_RISC trace buffer.
// Contents:
//   trace_state_e - FSM state encoding, also driven onto the state output
//   trace_mode_e  - trigger mode encoding; MODE_RSVD behaves as MODE_FILL
//   entry_w()     - width of one packed entry {pc, wb_en, wb_reg, wb_data}
package pa_risc_trace_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_POST = 2'd2,
    ST_DONE = 2'd3
  } trace_state_e;

  typedef enum logic [1:0] {
    MODE_FILL = 2'd0,
    MODE_PC   = 2'd1,
    MODE_REG  = 2'd2,
    MODE_RSVD = 2'd3
  } trace_mode_e;

  localparam int unsigned DEF_PC_W   = 32;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_REG_AW = 5;
  localparam int unsigned DEF_DEPTH  = 16;

  // Entry layout, MSB first: pc | wb_en | wb_reg | wb_data
  function automatic int unsigned entry_w(int unsigned pc_w, int unsigned reg_aw,
                                          int unsigned data_w);
    return pc_w + 1 + reg_aw + data_w;
  endfunction

endpackage

// File: rtl/pa_risc_trace_buffer_if.sv
// Bus interface of the trace buffer: control, pipeline observation and
// trace readout.
// Handshake: rd_valid/rd_ready. An entry transfers on a rising clk edge
// where rd_valid & rd_ready are both 1. While rd_valid=1 and rd_ready=0
// the rd_* fields hold stable. rd_valid does not depend on rd_ready.
// Modports:
//   slave  - the trace buffer (inputs: control + pipeline + rd_ready)
//   master - the pipeline/consumer side driving it
interface pa_risc_trace_buffer_if #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 16,
  parameter int CW     = $clog2(DEPTH) + 1
);
  logic              arm;
  logic [1:0]        mode;
  logic [PC_W-1:0]   trig_pc;
  logic [REG_AW-1:0] trig_reg;
  logic [CW-1:0]     post_cnt;
  logic              stall;
  logic [PC_W-1:0]   pc_in;
  logic              wb_en;
  logic [REG_AW-1:0] wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [PC_W-1:0]   rd_pc;
  logic              rd_wb_en;
  logic [REG_AW-1:0] rd_reg;
  logic [DATA_W-1:0] rd_data;
  logic [1:0]        state;
  logic              triggered;
  logic [CW-1:0]     count;

  modport slave (
    input  arm, mode, trig_pc, trig_reg, post_cnt, stall,
           pc_in, wb_en, wb_reg, wb_data, rd_ready,
    output rd_valid, rd_pc, rd_wb_en, rd_reg, rd_data, state, triggered, count
  );

  modport master (
    output arm, mode, trig_pc, trig_reg, post_cnt, stall,
           pc_in, wb_en, wb_reg, wb_data, rd_ready,
    input  rd_valid, rd_pc, rd_wb_en, rd_reg, rd_data, state, triggered, count
  );
endinterface

// File: rtl/pa_risc_trace_buffer_mem.sv
// Trace storage: DEPTH x W register array, one synchronous write port and
// one asynchronous read port. Contents are not reset; the top gates the
// read data so stale contents never reach the outputs.
// Ports:
//   clk      - write clock
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - read address
//   rdata_o  - read data (combinational)
module pa_risc_trace_buffer_mem #(
  parameter int W     = 70,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/pa_risc_trace_buffer.sv
// PA_RISC pipeline trace buffer. Captures {pc, wb_en, wb_reg, wb_data} once
// per unstalled cycle into a circular buffer, stops on fill / PC match /
// register-write match plus a post-trigger count, then streams the trace
// oldest-first over the rd_valid/rd_ready port.
// Ports:
//   clk   - clock, all state updates on the rising edge
//   reset - asynchronous active-high reset
//   bus   - pa_risc_trace_buffer_if.slave (control, pipeline, readout, status)
module pa_risc_trace_buffer
  import pa_risc_trace_buffer_pkg::*;
#(
  parameter int PC_W   = DEF_PC_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CW     = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  pa_risc_trace_buffer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = entry_w(PC_W, REG_AW, DATA_W);
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0] POST_MAX_C = CW'(DEPTH - 1);

  trace_state_e  state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [CW-1:0] post_q, post_d;
  logic          trig_q, trig_d;

  trace_mode_e   mode_e;
  logic          capture, match, use_trig, go_done, rd_fire;
  logic [CW-1:0] count_inc, post_clamp;
  logic [EW-1:0] rdata;

  assign mode_e   = trace_mode_e'(bus.mode);
  assign use_trig = (mode_e == MODE_PC) || (mode_e == MODE_REG);
  // arm wins over a same-cycle capture: that sample is dropped.
  assign capture  = ((state_q == ST_PRE) || (state_q == ST_POST)) && !bus.stall && !bus.arm;
  assign count_inc  = (count_q == DEPTH_C) ? count_q : count_q + 1'b1;
  assign post_clamp = (bus.post_cnt > POST_MAX_C) ? POST_MAX_C : bus.post_cnt;
  assign rd_fire    = bus.rd_valid && bus.rd_ready;

  always_comb begin
    match = 1'b0;
    case (mode_e)
      MODE_PC:  match = (bus.pc_in == bus.trig_pc);
      MODE_REG: match = bus.wb_en && (bus.wb_reg == bus.trig_reg);
      default:  match = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    rem_d   = rem_q;
    post_d  = post_q;
    trig_d  = trig_q;
    go_done = 1'b0;
    if (bus.arm) begin
      state_d = ST_PRE;
      wptr_d  = '0;
      count_d = '0;
      rem_d   = '0;
      post_d  = '0;
      trig_d  = 1'b0;
    end else begin
      case (state_q)
        ST_PRE: begin
          if (capture) begin
            wptr_d  = wptr_q + 1'b1;
            count_d = count_inc;
            if (use_trig) begin
              if (match) begin
                trig_d = 1'b1;
                post_d = post_clamp;
                if (post_clamp == '0) go_done = 1'b1;
                else                  state_d = ST_POST;
              end
            end else if (count_inc == DEPTH_C) begin
              go_done = 1'b1;
            end
          end
        end
        ST_POST: begin
          // post_q is at least 1 whenever POST is entered.
          if (capture) begin
            wptr_d  = wptr_q + 1'b1;
            count_d = count_inc;
            post_d  = post_q - 1'b1;
            if (post_q == CW'(1)) go_done = 1'b1;
          end
        end
        ST_DONE: begin
          if (rd_fire) begin
            rptr_d = rptr_q + 1'b1;
            rem_d  = rem_q - 1'b1;
          end
        end
        default: ;
      endcase
      // Oldest entry sits count positions behind the write pointer;
      // with a full buffer that is the write pointer itself.
      if (go_done) begin
        state_d = ST_DONE;
        rptr_d  = wptr_d - count_d[AW-1:0];
        rem_d   = count_d;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      rem_q   <= '0;
      post_q  <= '0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      post_q  <= post_d;
      trig_q  <= trig_d;
    end
  end

  pa_risc_trace_buffer_mem #(.W(EW), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .we_i    (capture),
    .waddr_i (wptr_q),
    .wdata_i ({bus.pc_in, bus.wb_en, bus.wb_reg, bus.wb_data}),
    .raddr_i (rptr_q),
    .rdata_o (rdata)
  );

  assign bus.rd_valid  = (state_q == ST_DONE) && (rem_q != '0);
  // Zero the fields when no entry is offered so unreset memory never shows.
  assign {bus.rd_pc, bus.rd_wb_en, bus.rd_reg, bus.rd_data} = bus.rd_valid ? rdata : '0;
  assign bus.state     = state_q;
  assign bus.triggered = trig_q;
  assign bus.count     = count_q;
endmodule

// File: tb/tb_pa_risc_trace_buffer.sv
module tb_pa_risc_trace_buffer;
  localparam int PC_W = 32, DATA_W = 32, REG_AW = 5, DEPTH = 8, CW = 4;
  localparam int EW = PC_W + 1 + REG_AW + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pa_risc_trace_buffer_if #(.PC_W(PC_W), .DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH)) bus ();

  pa_risc_trace_buffer #(.PC_W(PC_W), .DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] tpc;
    logic [4:0]  treg;
    logic [3:0]  post;
    int          skip_lo;
    int          skip_hi;
    int          exp_first;
    int          exp_last;
    int          exp_count;
    logic        exp_trig;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Writeback fields are a fixed function of the PC so every entry is unique.
  function automatic logic [EW-1:0] entry_of(input logic [31:0] pc);
    logic        en;
    logic [4:0]  rg;
    logic [31:0] dt;
    en = pc[7] | (pc[3:2] != 2'b11);
    rg = pc[6:2];
    dt = {pc[31:8], 3'b000, pc[6:2]} + 32'd2;
    return {pc, en, rg, dt};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pc(input logic [31:0] pc, input logic st);
    logic [EW-1:0] e;
    e = entry_of(pc);
    bus.pc_in   = pc;
    bus.wb_en   = e[37];
    bus.wb_reg  = e[36:32];
    bus.wb_data = e[31:0];
    bus.stall   = st;
  endtask

  task automatic push_expected(input int first, input int last, input int lo, input int hi);
    for (int p = first; p <= last; p += 4)
      if (!(p >= lo && p <= hi)) exp_q.push_back(entry_of(32'(p)));
  endtask

  task automatic do_arm(input logic [1:0] mode, input logic [31:0] tpc,
                        input logic [4:0] treg, input logic [3:0] post);
    bus.mode     = mode;
    bus.trig_pc  = tpc;
    bus.trig_reg = treg;
    bus.post_cnt = post;
    bus.rd_ready = 1'b0;
    // A sample presented with arm must be dropped; give it an unmatched PC.
    drive_pc(32'h0000_DEAC, 1'b0);
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    check("arm_state", EW'(bus.state), EW'(2'd1));
    check("arm_count", EW'(bus.count), '0);
    check("arm_triggered", EW'(bus.triggered), '0);
  endtask

  task automatic run_capture(input int lo, input int hi, output int last_pc, output logic done);
    int pc;
    int cap;
    logic st;
    pc = 0;
    cap = 0;
    done = 1'b0;
    last_pc = -1;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      st = (pc >= lo && pc <= hi);
      drive_pc(32'(pc), st);
      if (!st) cap++;
      tick();
      check("count_track", EW'(bus.count), EW'((cap > DEPTH) ? DEPTH : cap));
      if (bus.state == 2'd3) begin
        done = 1'b1;
        last_pc = pc;
      end
      pc += 4;
    end
    bus.stall = 1'b0;
    check("done_reached", EW'(done), EW'(1'b1));
  endtask

  task automatic drain();
    int budget;
    logic rdy;
    budget = 100;
    while (exp_q.size() > 0 && budget > 0) begin
      rdy = 1'($urandom_range(0, 1));
      bus.rd_ready = rdy;
      check("rd_valid_drain", EW'(bus.rd_valid), EW'(1'b1));
      if (rdy) begin
        check("rd_entry", {bus.rd_pc, bus.rd_wb_en, bus.rd_reg, bus.rd_data}, exp_q[0]);
        void'(exp_q.pop_front());
      end
      tick();
      budget--;
    end
    check("drain_left", EW'(exp_q.size()), '0);
    exp_q.delete();
    bus.rd_ready = 1'b1;
    tick();
    check("rd_valid_empty", EW'(bus.rd_valid), '0);
    check("state_after_drain", EW'(bus.state), EW'(2'd3));
    bus.rd_ready = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    int   last_pc;
    int   pc;
    logic done;
    logic [31:0] first_pc;
    logic [EW-1:0] head;

    bus.arm = 1'b0; bus.mode = 2'd0; bus.trig_pc = '0; bus.trig_reg = '0;
    bus.post_cnt = '0; bus.rd_ready = 1'b0;
    drive_pc(32'd0, 1'b0);

    //            mode   tpc     treg  post  slo  shi  first last cnt trig
    vecs[0] = '{2'd0, 32'd0,   5'd0, 4'd0,  1,   0,   0,   28,  8, 1'b0};
    vecs[1] = '{2'd1, 32'd40,  5'd0, 4'd2,  1,   0,   20,  48,  8, 1'b1};
    vecs[2] = '{2'd0, 32'd0,   5'd0, 4'd0,  12,  20,  0,   40,  8, 1'b0};
    vecs[3] = '{2'd2, 32'd0,   5'd5, 4'd0,  1,   0,   0,   20,  6, 1'b1};
    vecs[4] = '{2'd3, 32'd0,   5'd0, 4'd0,  1,   0,   0,   28,  8, 1'b0};
    vecs[5] = '{2'd1, 32'd8,   5'd0, 4'd15, 1,   0,   8,   36,  8, 1'b1};
    vecs[6] = '{2'd1, 32'd0,   5'd0, 4'd0,  1,   0,   0,   0,   1, 1'b1};
    vecs[7] = '{2'd2, 32'd0,   5'd3, 4'd1,  1,   0,   116, 144, 8, 1'b1};

    // Reset held for 3 time units.
    #2;
    check("reset_state", EW'(bus.state), '0);
    check("reset_count", EW'(bus.count), '0);
    check("reset_rd_valid", EW'(bus.rd_valid), '0);
    check("reset_triggered", EW'(bus.triggered), '0);
    check("reset_rd_fields", {bus.rd_pc, bus.rd_wb_en, bus.rd_reg, bus.rd_data}, '0);
    #1 reset = 1'b0;
    tick();
    check("idle_state", EW'(bus.state), '0);

    foreach (vecs[i]) begin
      push_expected(vecs[i].exp_first, vecs[i].exp_last, vecs[i].skip_lo, vecs[i].skip_hi);
      do_arm(vecs[i].mode, vecs[i].tpc, vecs[i].treg, vecs[i].post);
      run_capture(vecs[i].skip_lo, vecs[i].skip_hi, last_pc, done);
      check($sformatf("vec%0d_last_pc", i), EW'(last_pc), EW'(vecs[i].exp_last));
      check($sformatf("vec%0d_count", i), EW'(bus.count), EW'(vecs[i].exp_count));
      check($sformatf("vec%0d_triggered", i), EW'(bus.triggered), EW'(vecs[i].exp_trig));
      drain();
    end

    // Re-arm during POST, then hold off the reader in DONE.
    do_arm(2'd1, 32'd16, 5'd0, 4'd5);
    pc = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      drive_pc(32'(pc), 1'b0);
      tick();
      pc += 4;
      if (bus.state == 2'd2) break;
    end
    check("post_reached", EW'(bus.state), EW'(2'd2));
    check("post_triggered", EW'(bus.triggered), EW'(1'b1));
    do_arm(2'd0, 32'd0, 5'd0, 4'd0);
    push_expected(0, 28, 1, 0);
    run_capture(1, 0, last_pc, done);
    check("rearm_last_pc", EW'(last_pc), EW'(28));
    head = exp_q[0];
    first_pc = head[EW-1:EW-PC_W];
    bus.rd_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hold_rd_valid", EW'(bus.rd_valid), EW'(1'b1));
      check("hold_rd_pc", EW'(bus.rd_pc), EW'(first_pc));
    end
    drain();

    // Re-arm in the middle of a readout.
    push_expected(0, 28, 1, 0);
    do_arm(2'd0, 32'd0, 5'd0, 4'd0);
    run_capture(1, 0, last_pc, done);
    bus.rd_ready = 1'b1;
    tick();
    tick();
    do_arm(2'd0, 32'd0, 5'd0, 4'd0);
    check("midread_rd_valid", EW'(bus.rd_valid), '0);
    run_capture(1, 0, last_pc, done);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
